retime_flow_ctrl: RTL and testbench

- Controller for a STAGES-deep retime shift register datapath whose stages share one `flow` enable.
- Adds valid/ready handshakes around the datapath and tracks per-stage valid bits.
- Generates `flow` from downstream backpressure.
- Provides a flush sequence, an occupancy count and a saturating stall counter.
- Sits beside each retime wrapper; the datapath's data in/out pass through untouched.

---
 rtl/retime_flow_ctrl.sv | 114 +++++++++++
 tb/tb_retime_flow_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/retime_flow_ctrl.sv
// Valid/ready + flush controller for a shared-enable retime shift register; latency STAGES cycles per accepted beat.
// Backpressure: a non-accepting downstream with valid output drops sr_flow and freezes every stage (no bubble collapse).
module retime_flow_ctrl #(
    parameter int STAGES  = 1,
    parameter int STALL_W = 16,
    parameter int OCC_W   = $clog2(STAGES + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sr_flow,
    output logic               sr_reset,
    input  logic               flush,
    output logic               flush_done,
    output logic               busy,
    output logic [OCC_W-1:0]   occupancy,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_nxt;
    logic              in_fire;
    logic              out_fire;

    // reset gates flow directly so the datapath never shifts while held in reset
    assign sr_reset  = !reset;
    assign out_valid = v[STAGES-1];
    assign sr_flow   = reset && enable && (out_ready || !out_valid);
    assign in_ready  = sr_flow && (state == RUN);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready && enable;
    assign busy      = (state == FLUSH);

    always_comb begin
        v_nxt    = v;
        v_nxt[0] = in_fire;
        for (int i = 1; i < STAGES; i++) begin
            v_nxt[i] = v[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v <= '0;
        end else if (sr_flow) begin
            v <= v_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            occupancy <= '0;
        end else begin
            case ({in_fire, out_fire})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

    // drain completion is judged on the registered count, so flush_done lands one cycle after it reads zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= RUN;
            flush_done <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                RUN: begin
                    if (flush) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (occupancy == '0) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= RUN;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    occ_matches_valid_bits: assert property (
        @(posedge clock) disable iff (!reset) occupancy == OCC_W'($countones(v))
    );

endmodule

// File: tb/tb_retime_flow_ctrl.sv
// Bench for retime_flow_ctrl (STAGES=3, STALL_W=4) against a latency-counter reference model.
module tb_retime_flow_ctrl;

    localparam int STAGES  = 3;
    localparam int STALL_W = 4;
    localparam int OCC_W   = $clog2(STAGES + 1);
    localparam int SAT     = (1 << STALL_W) - 1;

    logic               clock     = 1'b0;
    logic               reset     = 1'b0;
    logic               enable    = 1'b0;
    logic               in_valid  = 1'b0;
    logic               out_ready = 1'b0;
    logic               flush     = 1'b0;
    logic               in_ready;
    logic               out_valid;
    logic               sr_flow;
    logic               sr_reset;
    logic               flush_done;
    logic               busy;
    logic [OCC_W-1:0]   occupancy;
    logic [STALL_W-1:0] stall_cnt;

    int nvec = 0;
    int nerr = 0;

    // Model: each in-flight beat carries the number of flow edges it has seen;
    // a beat is presented downstream once it has seen STAGES flow edges.
    int q[$];
    int m_state;   // 0 run, 1 flushing, 2 done
    int m_stall;
    bit m_done;

    retime_flow_ctrl #(.STAGES(STAGES), .STALL_W(STALL_W)) dut (
        .clock(clock), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .sr_flow(sr_flow), .sr_reset(sr_reset),
        .flush(flush), .flush_done(flush_done), .busy(busy),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_ov();
        return (q.size() > 0) && (q[0] == STAGES);
    endfunction

    function automatic bit m_flow();
        return reset && enable && (out_ready || !m_ov());
    endfunction

    function automatic bit m_in_ready();
        return m_flow() && (m_state == 0);
    endfunction

    task automatic model_clear();
        q.delete();
        m_state = 0;
        m_stall = 0;
        m_done  = 0;
    endtask

    task automatic model_edge();
        bit fl, inf, ov;
        if (!reset) begin
            model_clear();
            return;
        end
        ov  = m_ov();
        fl  = m_flow();
        inf = in_valid && m_in_ready();
        if (ov && !out_ready && m_stall < SAT) m_stall++;
        m_done = 0;
        case (m_state)
            0: if (flush) m_state = 1;
            1: if (q.size() == 0) begin m_state = 2; m_done = 1; end
            default: m_state = 0;
        endcase
        if (fl) begin
            if (ov) void'(q.pop_front());
            foreach (q[i]) q[i]++;
            if (inf) q.push_back(1);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic drain(input string tag);
        int k;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        enable    = 1'b1;
        k = 0;
        while (q.size() != 0 && k < 30) begin tick(); k++; end
        @(negedge clock);
        nvec++;
        if (occupancy !== 0) begin
            nerr++;
            $display("FAIL %s_drain: occupancy got %0d want 0", tag, occupancy);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; enable = 1'b1; out_ready = 1'b1; in_valid = 1'b1; flush = 1'b0;
        model_clear();
        repeat (3) @(posedge clock);
        @(negedge clock);
        nvec++; if (out_valid !== 1'b0)  begin nerr++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        nvec++; if (occupancy !== 0)     begin nerr++; $display("FAIL rst_occupancy: got %0d want 0", occupancy); end
        nvec++; if (stall_cnt !== 0)     begin nerr++; $display("FAIL rst_stall_cnt: got %0d want 0", stall_cnt); end
        nvec++; if (flush_done !== 1'b0) begin nerr++; $display("FAIL rst_flush_done: got %b want 0", flush_done); end
        nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL rst_busy: got %b want 0", busy); end
        nvec++; if (sr_reset !== 1'b1)   begin nerr++; $display("FAIL rst_sr_reset: got %b want 1", sr_reset); end
        nvec++; if (sr_flow !== 1'b0)    begin nerr++; $display("FAIL rst_sr_flow: got %b want 0", sr_flow); end
        nvec++; if (in_ready !== 1'b0)   begin nerr++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        nvec++; if (sr_reset !== 1'b0)   begin nerr++; $display("FAIL rel_sr_reset: got %b want 0", sr_reset); end
        tick();
    endtask

    task automatic test_fill();
        enable = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c <= 4);
            @(negedge clock);
            if (c <= 4) begin
                nvec++;
                if (in_ready !== 1'b1) begin nerr++; $display("FAIL fill_in_ready c%0d: got %b want 1", c, in_ready); end
            end
            nvec++;
            if (out_valid !== (c >= 3 && c <= 7)) begin
                nerr++; $display("FAIL fill_out_valid c%0d: got %b want %b", c, out_valid, (c >= 3 && c <= 7));
            end
            nvec++;
            if (occupancy !== q.size()) begin
                nerr++; $display("FAIL fill_occupancy c%0d: got %0d want %0d", c, occupancy, q.size());
            end
            tick();
        end
    endtask

    task automatic test_stall();
        enable = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        repeat (3) tick();
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            nvec++; if (sr_flow !== 1'b0)  begin nerr++; $display("FAIL stall_sr_flow s%0d: got %b want 0", s, sr_flow); end
            nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL stall_in_ready s%0d: got %b want 0", s, in_ready); end
            nvec++; if (occupancy !== 3)   begin nerr++; $display("FAIL stall_occupancy s%0d: got %0d want 3", s, occupancy); end
            nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL stall_out_valid s%0d: got %b want 1", s, out_valid); end
            tick();
        end
        @(negedge clock);
        nvec++; if (stall_cnt !== 5) begin nerr++; $display("FAIL stall_count: got %0d want 5", stall_cnt); end
        out_ready = 1'b1;
        for (int s = 0; s < 6; s++) begin
            @(negedge clock);
            nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL resume_out_valid s%0d: got %b want 1", s, out_valid); end
            nvec++; if (in_ready !== 1'b1)  begin nerr++; $display("FAIL resume_in_ready s%0d: got %b want 1", s, in_ready); end
            nvec++; if (occupancy !== 3)    begin nerr++; $display("FAIL resume_occupancy s%0d: got %0d want 3", s, occupancy); end
            tick();
        end
        nvec++; if (stall_cnt !== m_stall) begin nerr++; $display("FAIL resume_stall_cnt: got %0d want %0d", stall_cnt, m_stall); end
    endtask

    task automatic test_flush();
        int zero_c, done_c, done_n, ready_c;
        drain("flush");
        in_valid = 1'b1;
        repeat (2) tick();
        flush = 1'b1;
        @(negedge clock);
        nvec++; if (occupancy !== 2)   begin nerr++; $display("FAIL flush_start_occ: got %0d want 2", occupancy); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL flush_start_in_ready: got %b want 1", in_ready); end
        tick();
        flush = 1'b0;
        zero_c = -1; done_c = -1; done_n = 0; ready_c = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            nvec++; if (busy !== (m_state == 1)) begin nerr++; $display("FAIL flush_busy k%0d: got %b want %b", k, busy, (m_state == 1)); end
            nvec++; if (flush_done !== m_done)  begin nerr++; $display("FAIL flush_done k%0d: got %b want %b", k, flush_done, m_done); end
            nvec++; if (occupancy !== q.size()) begin nerr++; $display("FAIL flush_occ k%0d: got %0d want %0d", k, occupancy, q.size()); end
            nvec++; if (in_ready !== m_in_ready()) begin nerr++; $display("FAIL flush_in_ready k%0d: got %b want %b", k, in_ready, m_in_ready()); end
            if (occupancy == 0 && zero_c < 0) zero_c = k;
            if (flush_done === 1'b1) begin done_n++; done_c = k; end
            if (in_ready === 1'b1 && ready_c < 0) ready_c = k;
            tick();
        end
        nvec++; if (done_n !== 1) begin nerr++; $display("FAIL flush_done_count: got %0d want 1", done_n); end
        nvec++; if (done_c !== zero_c + 1) begin nerr++; $display("FAIL flush_done_timing: got cycle %0d want %0d", done_c, zero_c + 1); end
        nvec++; if (ready_c !== done_c + 1) begin nerr++; $display("FAIL flush_ready_return: got cycle %0d want %0d", ready_c, done_c + 1); end
        nvec++; if (zero_c !== 4) begin nerr++; $display("FAIL flush_zero_cycle: got %0d want 4", zero_c); end
    endtask

    task automatic test_flush_empty();
        drain("flush_empty");
        flush = 1'b1;
        @(negedge clock);
        nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL fe_busy0: got %b want 0", busy); end
        tick();
        flush = 1'b0;
        @(negedge clock);
        nvec++; if (busy !== 1'b1)       begin nerr++; $display("FAIL fe_busy1: got %b want 1", busy); end
        nvec++; if (flush_done !== 1'b0) begin nerr++; $display("FAIL fe_done1: got %b want 0", flush_done); end
        nvec++; if (in_ready !== 1'b0)   begin nerr++; $display("FAIL fe_ready1: got %b want 0", in_ready); end
        tick();
        @(negedge clock);
        nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL fe_busy2: got %b want 0", busy); end
        nvec++; if (flush_done !== 1'b1) begin nerr++; $display("FAIL fe_done2: got %b want 1", flush_done); end
        nvec++; if (in_ready !== 1'b0)   begin nerr++; $display("FAIL fe_ready2: got %b want 0", in_ready); end
        tick();
        @(negedge clock);
        nvec++; if (flush_done !== 1'b0) begin nerr++; $display("FAIL fe_done3: got %b want 0", flush_done); end
        nvec++; if (in_ready !== 1'b1)   begin nerr++; $display("FAIL fe_ready3: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_reset_midflush();
        drain("midflush");
        in_valid = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clock);
        nvec++; if (busy !== 1'b1)      begin nerr++; $display("FAIL mf_busy: got %b want 1", busy); end
        nvec++; if (occupancy !== 2)    begin nerr++; $display("FAIL mf_occ: got %0d want 2", occupancy); end
        nvec++; if (out_valid !== 1'b1) begin nerr++; $display("FAIL mf_out_valid: got %b want 1", out_valid); end
        #2;
        reset = 1'b0;
        model_clear();
        #1;
        nvec++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL mf_rst_out_valid: got %b want 0", out_valid); end
        nvec++; if (occupancy !== 0)    begin nerr++; $display("FAIL mf_rst_occ: got %0d want 0", occupancy); end
        nvec++; if (sr_reset !== 1'b1)  begin nerr++; $display("FAIL mf_rst_sr_reset: got %b want 1", sr_reset); end
        nvec++; if (busy !== 1'b0)      begin nerr++; $display("FAIL mf_rst_busy: got %b want 0", busy); end
        tick();
        @(negedge clock);
        reset = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            nvec++; if (flush_done !== 1'b0) begin nerr++; $display("FAIL mf_post_done k%0d: got %b want 0", k, flush_done); end
            nvec++; if (busy !== 1'b0)       begin nerr++; $display("FAIL mf_post_busy k%0d: got %b want 0", k, busy); end
            nvec++; if (in_ready !== 1'b1)   begin nerr++; $display("FAIL mf_post_ready k%0d: got %b want 1", k, in_ready); end
            tick();
        end
    endtask

    task automatic test_stall_saturate();
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        tick();
        @(negedge clock);
        reset = 1'b1;
        tick();
        enable = 1'b1; out_ready = 1'b0; in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clock);
            nvec++;
            if (stall_cnt !== ((k < SAT) ? k : SAT)) begin
                nerr++; $display("FAIL sat_stall_cnt k%0d: got %0d want %0d", k, stall_cnt, (k < SAT) ? k : SAT);
            end
            if (k < 20) tick();
        end
        nvec++; if (stall_cnt !== 4'd15) begin nerr++; $display("FAIL sat_final: got %0d want 15", stall_cnt); end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            enable    = ($urandom % 8) != 0;
            in_valid  = $urandom % 2;
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 24) == 0;
            @(negedge clock);
            nvec++;
            if ({sr_flow, in_ready, out_valid, busy, flush_done} !==
                {m_flow(), m_in_ready(), m_ov(), (m_state == 1), m_done}) begin
                nerr++;
                $display("FAIL rnd_ctrl c%0d: got flow/ir/ov/busy/done=%b%b%b%b%b want %b%b%b%b%b", c,
                         sr_flow, in_ready, out_valid, busy, flush_done,
                         m_flow(), m_in_ready(), m_ov(), (m_state == 1), m_done);
            end
            nvec++;
            if (occupancy !== q.size()) begin
                nerr++; $display("FAIL rnd_occupancy c%0d: got %0d want %0d", c, occupancy, q.size());
            end
            nvec++;
            if (stall_cnt !== m_stall) begin
                nerr++; $display("FAIL rnd_stall_cnt c%0d: got %0d want %0d", c, stall_cnt, m_stall);
            end
            tick();
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_stall();
        test_flush();
        test_flush_empty();
        test_reset_midflush();
        test_stall_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
